// File: rtl/mux_mem_src_sync.sv
// mux_mem_src_sync: hitless N-way registered selector for the DDR write-control
// bundle. A source change drains the current source's active write, then
// inserts a guard gap, and only then hands the outputs to the new source.
module mux_mem_src_sync #(
    parameter int NSRC      = 4,
    parameter int SELW      = 2,
    parameter int PAT_W     = 2,
    parameter int PAGE_W    = 32,
    parameter int GUARD_CYC = 4,
    parameter int DRAIN_MAX = 1024,
    parameter int RESET_SEL = 0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [SELW-1:0]         SEL_REQ,
    input  logic [NSRC-1:0]         SRC_MEM_WEN,
    input  logic [NSRC-1:0]         SRC_PATTERN_EN,
    input  logic [NSRC*PAT_W-1:0]   SRC_PATTERN,
    input  logic [NSRC*PAGE_W-1:0]  SRC_WRITE_PAGE_NO,
    output logic                    MEM_WEN,
    output logic                    PATTERN_EN,
    output logic [PAT_W-1:0]        PATTERN,
    output logic [PAGE_W-1:0]       WRITE_PAGE_NO,
    output logic [SELW-1:0]         SEL_ACTIVE,
    output logic                    SWITCHING,
    output logic                    SEL_ERR,
    output logic                    DRAIN_TO
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_GUARD  = 2'd2
    } state_t;

    localparam logic [SELW-1:0] RST_SEL    = SELW'(RESET_SEL);
    localparam logic [15:0]     DRAIN_LAST = 16'(DRAIN_MAX - 1);
    localparam logic [7:0]      GUARD_LAST = 8'(GUARD_CYC - 1);

    state_t              state_q, state_d;
    logic [SELW-1:0]     tgt_q, tgt_d;
    logic [SELW-1:0]     sel_q, sel_d;
    logic [15:0]         dcnt_q, dcnt_d;
    logic [7:0]          gcnt_q, gcnt_d;
    logic                wen_q, wen_d;
    logic                pen_q, pen_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic                sw_q, sw_d;
    logic                err_q, err_d;
    logic                to_q, to_d;

    logic                sel_valid;
    logic [PAT_W-1:0]    pat_arr  [NSRC];
    logic [PAGE_W-1:0]   page_arr [NSRC];

    // A request is only meaningful when it names an existing source; with a
    // power-of-two source count every encoding is legal.
    if (NSRC == (1 << SELW)) begin : g_valid_all
        assign sel_valid = 1'b1;
    end else begin : g_valid_cmp
        assign sel_valid = (SEL_REQ < SELW'(NSRC));
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_unpack
        assign pat_arr[i]  = SRC_PATTERN[i*PAT_W +: PAT_W];
        assign page_arr[i] = SRC_WRITE_PAGE_NO[i*PAGE_W +: PAGE_W];
    end

    // Next-state and next-output logic for the ACTIVE/DRAIN/GUARD selector.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        sel_d   = sel_q;
        dcnt_d  = dcnt_q;
        gcnt_d  = gcnt_q;
        wen_d   = SRC_MEM_WEN[sel_q];
        pen_d   = SRC_PATTERN_EN[sel_q];
        pat_d   = pat_arr[sel_q];
        page_d  = page_arr[sel_q];
        err_d   = 1'b0;
        to_d    = 1'b0;

        // An out-of-range request never disturbs the pending target.
        if (sel_valid) begin
            tgt_d = SEL_REQ;
        end

        case (state_q)
            ST_ACTIVE: begin
                if (!sel_valid) begin
                    err_d = 1'b1;
                end else if (SEL_REQ != sel_q) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = 16'd0;
                end
            end
            ST_DRAIN: begin
                // Abort wins over idle, idle wins over timeout.
                if (tgt_d == sel_q) begin
                    state_d = ST_ACTIVE;
                end else if (!SRC_MEM_WEN[sel_q]) begin
                    state_d = ST_GUARD;
                    gcnt_d  = 8'd0;
                end else if (dcnt_q == DRAIN_LAST) begin
                    to_d    = 1'b1;
                    state_d = ST_GUARD;
                    gcnt_d  = 8'd0;
                end else begin
                    dcnt_d = dcnt_q + 16'd1;
                end
            end
            ST_GUARD: begin
                // Write strobes are forced off; data fields freeze so the
                // DDR path sees a stable bundle through the gap.
                wen_d  = 1'b0;
                pen_d  = 1'b0;
                pat_d  = pat_q;
                page_d = page_q;
                if (gcnt_q == GUARD_LAST) begin
                    sel_d   = tgt_d;
                    state_d = ST_ACTIVE;
                end else begin
                    gcnt_d = gcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase

        sw_d = (state_d != ST_ACTIVE);
    end

    // State, counters and registered outputs; reset returns to ACTIVE on RESET_SEL.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_ACTIVE;
            tgt_q   <= RST_SEL;
            sel_q   <= RST_SEL;
            dcnt_q  <= 16'd0;
            gcnt_q  <= 8'd0;
            wen_q   <= 1'b0;
            pen_q   <= 1'b0;
            pat_q   <= '0;
            page_q  <= '0;
            sw_q    <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            sel_q   <= sel_d;
            dcnt_q  <= dcnt_d;
            gcnt_q  <= gcnt_d;
            wen_q   <= wen_d;
            pen_q   <= pen_d;
            pat_q   <= pat_d;
            page_q  <= page_d;
            sw_q    <= sw_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign MEM_WEN       = wen_q;
    assign PATTERN_EN    = pen_q;
    assign PATTERN       = pat_q;
    assign WRITE_PAGE_NO = page_q;
    assign SEL_ACTIVE    = sel_q;
    assign SWITCHING     = sw_q;
    assign SEL_ERR       = err_q;
    assign DRAIN_TO      = to_q;

endmodule

// File: tb/tb_mux_mem_src_sync.sv
// Directed bench for mux_mem_src_sync: a 4-source instance (short drain
// timeout) and a 3-source instance (out-of-range select codes).
module tb_mux_mem_src_sync;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    // 4-source instance
    logic [3:0]   a_wen_i = '0;
    logic [1:0]   a_req   = '0;
    logic [31:0]  a_pg0   = 32'h10;
    logic         a_wen, a_pen, a_sw, a_err, a_to;
    logic [1:0]   a_pat, a_sel;
    logic [31:0]  a_page;

    // 3-source instance
    logic [2:0]   b_wen_i = '0;
    logic [1:0]   b_req   = '0;
    logic         b_wen, b_pen, b_sw, b_err, b_to;
    logic [1:0]   b_pat, b_sel;
    logic [31:0]  b_page;

    mux_mem_src_sync #(
        .NSRC(4), .SELW(2), .PAT_W(2), .PAGE_W(32),
        .GUARD_CYC(4), .DRAIN_MAX(8), .RESET_SEL(0)
    ) dut_a (
        .CLK(CLK), .RESET(RESET), .SEL_REQ(a_req),
        .SRC_MEM_WEN(a_wen_i), .SRC_PATTERN_EN(a_wen_i),
        .SRC_PATTERN({2'd3, 2'd2, 2'd1, 2'd0}),
        .SRC_WRITE_PAGE_NO({32'h333, 32'h222, 32'h111, a_pg0}),
        .MEM_WEN(a_wen), .PATTERN_EN(a_pen), .PATTERN(a_pat),
        .WRITE_PAGE_NO(a_page), .SEL_ACTIVE(a_sel), .SWITCHING(a_sw),
        .SEL_ERR(a_err), .DRAIN_TO(a_to)
    );

    mux_mem_src_sync #(
        .NSRC(3), .SELW(2), .PAT_W(2), .PAGE_W(32),
        .GUARD_CYC(4), .DRAIN_MAX(1024), .RESET_SEL(0)
    ) dut_b (
        .CLK(CLK), .RESET(RESET), .SEL_REQ(b_req),
        .SRC_MEM_WEN(b_wen_i), .SRC_PATTERN_EN(b_wen_i),
        .SRC_PATTERN({2'd2, 2'd1, 2'd0}),
        .SRC_WRITE_PAGE_NO({32'hA2, 32'hA1, 32'hA0}),
        .MEM_WEN(b_wen), .PATTERN_EN(b_pen), .PATTERN(b_pat),
        .WRITE_PAGE_NO(b_page), .SEL_ACTIVE(b_sel), .SWITCHING(b_sw),
        .SEL_ERR(b_err), .DRAIN_TO(b_to)
    );

    typedef struct {
        int          d;
        logic        wen;
        logic [1:0]  pat;
        logic [31:0] page;
        logic [1:0]  sel;
        logic        sw;
        logic        err;
        logic        to;
    } exp_t;

    exp_t  sb[$];
    string tq[$];
    int    n_pass = 0;
    int    n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag, input int d);
        if (d == 0) begin
            chk({tag, ".wen"},  32'(a_wen),  0); chk({tag, ".pen"},  32'(a_pen),  0);
            chk({tag, ".pat"},  32'(a_pat),  0); chk({tag, ".page"}, a_page,      0);
            chk({tag, ".sel"},  32'(a_sel),  0); chk({tag, ".sw"},   32'(a_sw),   0);
            chk({tag, ".err"},  32'(a_err),  0); chk({tag, ".to"},   32'(a_to),   0);
        end else begin
            chk({tag, ".wen"},  32'(b_wen),  0); chk({tag, ".pen"},  32'(b_pen),  0);
            chk({tag, ".pat"},  32'(b_pat),  0); chk({tag, ".page"}, b_page,      0);
            chk({tag, ".sel"},  32'(b_sel),  0); chk({tag, ".sw"},   32'(b_sw),   0);
            chk({tag, ".err"},  32'(b_err),  0); chk({tag, ".to"},   32'(b_to),   0);
        end
    endtask

    // Drive one cycle of stimulus on instance d, queue the outputs expected
    // after the next edge, then pop and compare once that edge has passed.
    task automatic step(input int d, input logic [3:0] wen, input logic [1:0] req,
                        input logic [31:0] pg0, input logic ew, input logic [1:0] ep,
                        input logic [31:0] epg, input logic [1:0] es, input logic esw,
                        input logic eerr, input logic eto, input string tag);
        exp_t  e;
        string t;
        if (d == 0) begin
            a_wen_i = wen; a_req = req; a_pg0 = pg0;
        end else begin
            b_wen_i = wen[2:0]; b_req = req;
        end
        e.d = d; e.wen = ew; e.pat = ep; e.page = epg; e.sel = es;
        e.sw = esw; e.err = eerr; e.to = eto;
        sb.push_back(e);
        tq.push_back(tag);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        t = tq.pop_front();
        if (e.d == 0) begin
            chk({t, ".wen"},  32'(a_wen), 32'(e.wen));
            chk({t, ".pen"},  32'(a_pen), 32'(e.wen));
            chk({t, ".pat"},  32'(a_pat), 32'(e.pat));
            chk({t, ".page"}, a_page,     e.page);
            chk({t, ".sel"},  32'(a_sel), 32'(e.sel));
            chk({t, ".sw"},   32'(a_sw),  32'(e.sw));
            chk({t, ".err"},  32'(a_err), 32'(e.err));
            chk({t, ".to"},   32'(a_to),  32'(e.to));
        end else begin
            chk({t, ".wen"},  32'(b_wen), 32'(e.wen));
            chk({t, ".pen"},  32'(b_pen), 32'(e.wen));
            chk({t, ".pat"},  32'(b_pat), 32'(e.pat));
            chk({t, ".page"}, b_page,     e.page);
            chk({t, ".sel"},  32'(b_sel), 32'(e.sel));
            chk({t, ".sw"},   32'(b_sw),  32'(e.sw));
            chk({t, ".err"},  32'(b_err), 32'(e.err));
            chk({t, ".to"},   32'(b_to),  32'(e.to));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, then release between edges.
        #12;
        chk_idle("rst_a", 0);
        chk_idle("rst_b", 1);
        RESET = 1'b0;

        // 1-cycle latency from source 0 in ACTIVE.
        step(0, 4'b0000, 2'd0, 32'h10, 0, 0, 32'h10, 0, 0, 0, 0, "t1_first");
        step(0, 4'b0000, 2'd0, 32'h55, 0, 0, 32'h55, 0, 0, 0, 0, "t1_lat");
        step(0, 4'b0001, 2'd0, 32'h10, 1, 0, 32'h10, 0, 0, 0, 0, "t1_wen");

        // Request 3 then back to 0 while source 0 is busy: abort, no gap.
        step(0, 4'b0001, 2'd3, 32'h10, 1, 0, 32'h10, 0, 1, 0, 0, "t3_drain");
        step(0, 4'b0001, 2'd0, 32'h10, 1, 0, 32'h10, 0, 0, 0, 0, "t3_abort");
        step(0, 4'b0001, 2'd0, 32'h10, 1, 0, 32'h10, 0, 0, 0, 0, "t3_stay");

        // Switch 0 -> 2: drain while source 0 writes, guard gap, then source 2.
        for (int i = 0; i < 5; i++)
            step(0, 4'b0001, 2'd2, 32'h10, 1, 0, 32'h10, 0, 1, 0, 0, "t2_drain");
        step(0, 4'b0000, 2'd2, 32'h10, 0, 0, 32'h10, 0, 1, 0, 0, "t2_idle");
        for (int i = 0; i < 3; i++)
            step(0, 4'b0100, 2'd2, 32'h10, 0, 0, 32'h10, 0, 1, 0, 0, "t2_guard");
        step(0, 4'b0100, 2'd2, 32'h10, 0, 0, 32'h10, 2, 0, 0, 0, "t2_swap");
        step(0, 4'b0100, 2'd2, 32'h10, 1, 2, 32'h222, 2, 0, 0, 0, "t2_new");

        // Source 2 stuck busy, request 1: timeout after 8 drain cycles.
        step(0, 4'b0100, 2'd1, 32'h10, 1, 2, 32'h222, 2, 1, 0, 0, "t4_enter");
        for (int i = 0; i < 7; i++)
            step(0, 4'b0100, 2'd1, 32'h10, 1, 2, 32'h222, 2, 1, 0, 0, "t4_drain");
        step(0, 4'b0100, 2'd1, 32'h10, 1, 2, 32'h222, 2, 1, 0, 1, "t4_to");
        for (int i = 0; i < 3; i++)
            step(0, 4'b0100, 2'd1, 32'h10, 0, 2, 32'h222, 2, 1, 0, 0, "t4_guard");
        step(0, 4'b0100, 2'd1, 32'h10, 0, 2, 32'h222, 1, 0, 0, 0, "t4_swap");
        step(0, 4'b0110, 2'd1, 32'h10, 1, 1, 32'h111, 1, 0, 0, 0, "t4_new");

        // 3-source instance: code 3 is invalid.
        step(1, 4'b0000, 2'd3, 32'h0, 0, 0, 32'hA0, 0, 0, 1, 0, "t5_err1");
        step(1, 4'b0000, 2'd3, 32'h0, 0, 0, 32'hA0, 0, 0, 1, 0, "t5_err2");
        step(1, 4'b0000, 2'd1, 32'h0, 0, 0, 32'hA0, 0, 1, 0, 0, "t5_drain");
        step(1, 4'b0000, 2'd1, 32'h0, 0, 0, 32'hA0, 0, 1, 0, 0, "t5_idle");
        step(1, 4'b0000, 2'd3, 32'h0, 0, 0, 32'hA0, 0, 1, 0, 0, "t5_g_bad");
        step(1, 4'b0000, 2'd2, 32'h0, 0, 0, 32'hA0, 0, 1, 0, 0, "t5_g_re");
        step(1, 4'b0000, 2'd2, 32'h0, 0, 0, 32'hA0, 0, 1, 0, 0, "t5_g");
        step(1, 4'b0000, 2'd3, 32'h0, 0, 0, 32'hA0, 2, 0, 0, 0, "t5_swap");
        step(1, 4'b0100, 2'd2, 32'h0, 1, 2, 32'hA2, 2, 0, 0, 0, "t5_new");

        // Into GUARD on the 4-source instance, then reset mid-gap.
        step(0, 4'b0000, 2'd0, 32'h10, 0, 1, 32'h111, 1, 1, 0, 0, "t6_drain");
        step(0, 4'b0000, 2'd0, 32'h10, 0, 1, 32'h111, 1, 1, 0, 0, "t6_idle");
        step(0, 4'b0000, 2'd0, 32'h10, 0, 1, 32'h111, 1, 1, 0, 0, "t6_guard");
        #2;
        RESET = 1'b1;
        #1;
        chk_idle("t6_rst", 0);
        #2;
        RESET = 1'b0;
        step(0, 4'b0000, 2'd0, 32'h10, 0, 0, 32'h10, 0, 0, 0, 0, "t6_after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
